// File: rtl/riscv_pkg.sv
// Shared definitions for the 64-bit RISC-V pipeline: widths, branch funct3 codes
// and the EX/MEM control bundle carried alongside the datapath.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef struct packed {
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [RD_W-1:0] rd;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/branch_cond.sv
// Resolves a conditional branch from funct3 and the ALU zero/lt flags.
// Unsigned compares (BLTU/BGEU) are not resolved here and read as not taken.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = !zero;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch resolution, one-cycle fetch redirect and
// single-slot wrong-path squash. Optional BRANCH_STATS_EN adds branch counters.
module ex_mem_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RD_W = riscv_pkg::RD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_zero,
    input  logic            ex_lt,
    input  logic            ex_branch,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            stall,
    input  logic            flush,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [RD_W-1:0] mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     br_resolved_cnt,
    output logic [31:0]     br_taken_cnt
`endif
);
    import riscv_pkg::*;

    logic            cond;
    logic            take;
    logic            capture;
    logic            load;
    logic            squash_reg;
    logic            valid_reg;
    ex_mem_ctrl_t    ex_ctrl;
    ex_mem_ctrl_t    ctrl_reg;
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] store_data_reg;
    logic            redirect_valid_reg;
    logic [XLEN-1:0] redirect_pc_reg;

    branch_cond u_branch_cond (
        .funct3 (ex_funct3),
        .zero   (ex_zero),
        .lt     (ex_lt),
        .cond   (cond)
    );

    assign capture = !stall && !flush;
    assign load    = ex_valid && !squash_reg;
    assign take    = ex_valid && ex_branch && cond && !squash_reg;

    always_comb begin
        ex_ctrl           = '0;
        ex_ctrl.reg_write = ex_reg_write;
        ex_ctrl.mem_read  = ex_mem_read;
        ex_ctrl.mem_write = ex_mem_write;
        ex_ctrl.rd        = ex_rd;
    end

    // Control path: flush beats stall; a bubble zeroes the control bits but keeps rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            ctrl_reg   <= '0;
            squash_reg <= 1'b0;
        end else if (flush) begin
            valid_reg          <= 1'b0;
            ctrl_reg.reg_write <= 1'b0;
            ctrl_reg.mem_read  <= 1'b0;
            ctrl_reg.mem_write <= 1'b0;
            squash_reg         <= 1'b0;
        end else if (!stall) begin
            squash_reg <= take;
            if (load) begin
                valid_reg <= 1'b1;
                ctrl_reg  <= ex_ctrl;
            end else begin
                valid_reg          <= 1'b0;
                ctrl_reg.reg_write <= 1'b0;
                ctrl_reg.mem_read  <= 1'b0;
                ctrl_reg.mem_write <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg     <= '0;
            store_data_reg <= '0;
        end else if (capture && load) begin
            result_reg     <= ex_result;
            store_data_reg <= ex_store_data;
        end
    end

    // The pulse is recomputed every cycle so a following stall can never stretch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            redirect_valid_reg <= capture && take;
            if (capture && take) begin
                redirect_pc_reg <= ex_pc + ex_imm;
            end
        end
    end

    assign mem_valid      = valid_reg;
    assign mem_result     = result_reg;
    assign mem_store_data = store_data_reg;
    assign mem_rd         = ctrl_reg.rd;
    assign mem_reg_write  = ctrl_reg.reg_write;
    assign mem_mem_read   = ctrl_reg.mem_read;
    assign mem_mem_write  = ctrl_reg.mem_write;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;

`ifdef BRANCH_STATS_EN
    // Index 0 counts resolved (captured, non-squashed) branches, index 1 taken ones.
    logic [1:0] stat_inc;

    assign stat_inc[0] = capture && load && ex_branch;
    assign stat_inc[1] = capture && take;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [31:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi]) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign br_resolved_cnt = g_stat[0].cnt_reg;
    assign br_taken_cnt    = g_stat[1].cnt_reg;
`endif

endmodule
